// File: rtl/oam_dma.sv
// oam_dma: sprite DMA that halts the core and copies one 256-byte page to DEST_REG.
// The core's read cycle is stalled; READ always lands on an even parity cycle.
module oam_dma #(
    parameter logic [15:0] DMA_REG  = 16'h4014,
    parameter logic [15:0] DEST_REG = 16'h2004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_o,
    input  logic        cpu_rw,
    output logic        cpu_ready,
    input  logic [7:0]  mem_data_i,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_data_o,
    output logic        bus_rw,
    output logic        dma_active,
    output logic        dma_done
);
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE, RESUME} state_t;
    state_t state, state_nxt;
    logic [7:0] page, index;
    logic par, done, trig;
    assign trig = !cpu_rw && cpu_addr == DMA_REG;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            page  <= '0;
            index <= '0;
            par   <= 1'b0;
            done  <= 1'b0;
        end else begin
            par  <= ~par;
            done <= state == RESUME;
            if (state == IDLE && trig) begin
                page  <= cpu_data_o;
                index <= '0;
            end else if (state == WRITE) begin
                index <= index + 8'd1;
            end
        end
    end
    // the halt cycle picks READ only if the following cycle has even parity
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = trig ? HALT : IDLE;
            HALT:    state_nxt = cpu_rw ? (par ? READ : ALIGN) : HALT;
            ALIGN:   state_nxt = READ;
            READ:    state_nxt = WRITE;
            WRITE:   state_nxt = index == 8'hFF ? RESUME : READ;
            RESUME:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        cpu_ready  = state == IDLE;
        dma_active = state != IDLE;
        dma_done   = done;
        bus_addr   = state == READ ? {page, index} : state == WRITE ? DEST_REG : cpu_addr;
        bus_data_o = state == READ ? 8'h00 : state == WRITE ? mem_data_i : cpu_data_o;
        bus_rw     = state == READ ? 1'b1 : state == WRITE ? 1'b0 : cpu_rw;
    end
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: scoreboard bench; stimulus queues expected DMA bus cycles, a monitor checks them.
module tb_oam_dma;
    localparam logic [15:0] DMA = 16'h4014, DEST = 16'h2004, CORE = 16'h8000;
    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        rw;
    } ev_t;
    logic        clk = 1'b0, rst = 1'b1;
    logic [15:0] cpu_addr = CORE;
    logic [7:0]  cpu_data_o = 8'h00, mem_data_i = 8'h00;
    logic        cpu_rw = 1'b1;
    logic        cpu_ready, bus_rw, dma_active, dma_done;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_o;
    logic        tbpar = 1'b0;
    int checks = 0, errors = 0;
    ev_t q[$];
    ev_t e_mon;

    oam_dma dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_data_o(cpu_data_o), .cpu_rw(cpu_rw),
        .cpu_ready(cpu_ready), .mem_data_i(mem_data_i), .bus_addr(bus_addr),
        .bus_data_o(bus_data_o), .bus_rw(bus_rw), .dma_active(dma_active), .dma_done(dma_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fmem(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // synchronous memory with one-cycle read latency, plus a parity reference
    always @(posedge clk) begin
        tbpar <= rst ? 1'b0 : ~tbpar;
        mem_data_i <= fmem(bus_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drv(input logic [15:0] a, input logic [7:0] d, input logic rw);
        cpu_addr = a;
        cpu_data_o = d;
        cpu_rw = rw;
    endtask

    task automatic push_xfer(input logic [7:0] pg, input int n);
        for (int i = 0; i < n; i++) begin
            q.push_back('{a: {pg, 8'(i)}, d: 8'h00, rw: 1'b1});
            q.push_back('{a: DEST, d: fmem({pg, 8'(i)}), rw: 1'b0});
        end
    endtask

    // DMA-originated cycles: writes to DEST, or reads not matching the core's address
    always @(negedge clk) begin
        if (dma_active === 1'b1 && ((bus_rw == 1'b0 && bus_addr == DEST) ||
                                    (bus_rw == 1'b1 && bus_addr != cpu_addr))) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_dma: addr=%h rw=%b", bus_addr, bus_rw);
            end else begin
                e_mon = q.pop_front();
                chk("dma_addr", bus_addr, e_mon.a);
                chk("dma_rw", bus_rw, e_mon.rw);
                chk("dma_data", bus_data_o, e_mon.d);
            end
        end
    end

    task automatic xfer(input logic [7:0] pg, input bit align, input bit push, input bit forge,
                        input bit chain, input bit triggered, input logic [7:0] nxt);
        int cnt, dn, exp_n;
        bit go;
        exp_n = align ? 515 : 514;
        push_xfer(pg, 256);
        if (!triggered) begin
            @(posedge clk); #1;
            drv(DMA, pg, 1'b0);
            @(negedge clk);
            chk("trig_ready", cpu_ready, 1);
            chk("trig_pass", bus_addr, DMA);
        end
        go = 1'b0;
        for (int k = 0; k < 8 && !go; k++) begin
            @(posedge clk); #1;
            if (push && k == 0) drv(DMA, 8'h33, 1'b0);
            else if (push && k == 1) drv(16'h0300, 8'hA5, 1'b0);
            else if (tbpar != align) begin
                drv(CORE, 8'h00, 1'b1);
                go = 1'b1;
            end else drv(16'h0400, 8'h00, 1'b0);
            if (!go) begin
                @(negedge clk);
                chk("halt_ready", cpu_ready, 0);
                chk("halt_addr", bus_addr, cpu_addr);
                chk("halt_data", bus_data_o, cpu_data_o);
                chk("halt_rw", bus_rw, 0);
            end
        end
        chk("halt_read_issued", go, 1);
        cnt = 0;
        dn = 0;
        repeat (600) begin
            @(negedge clk);
            if (cpu_ready) break;
            cnt++;
            dn += int'(dma_done);
            @(posedge clk); #1;
            drv(CORE, 8'h00, 1'b1);
            if (forge && cnt >= 50 && cnt < 53) drv(DMA, 8'h77, 1'b0);
            if (chain && cnt == exp_n) drv(DMA, nxt, 1'b0);
        end
        chk("ready_low", cnt, exp_n);
        chk("done_early", dn, 0);
        chk("end_ready", cpu_ready, 1);
        chk("done_pulse", dma_done, 1);
        chk("resume_pass", bus_addr, cpu_addr);
        chk("q_empty", q.size(), 0);
        if (!chain) begin
            @(posedge clk); #1;
            drv(CORE, 8'h00, 1'b1);
            @(negedge clk);
            chk("done_once", dma_done, 0);
            chk("idle_active", dma_active, 0);
        end
    endtask

    initial begin
        int wcnt;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drv(CORE, 8'h00, 1'b1);
        @(negedge clk);
        chk("rst_ready", cpu_ready, 1);
        chk("rst_active", dma_active, 0);
        chk("rst_done", dma_done, 0);
        chk("rst_pass", bus_addr, CORE);
        xfer(8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        xfer(8'h35, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);
        xfer(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        push_xfer(8'h10, 100);
        @(posedge clk); #1;
        drv(DMA, 8'h10, 1'b0);
        @(posedge clk); #1;
        drv(CORE, 8'h00, 1'b1);
        wcnt = 0;
        repeat (1000) begin
            @(negedge clk);
            if (dma_active && !bus_rw && bus_addr == DEST) wcnt++;
            if (wcnt == 100) begin
                rst = 1'b1;
                break;
            end
        end
        chk("abort_writes", wcnt, 100);
        @(posedge clk); #1;
        rst = 1'b0;
        drv(CORE, 8'h00, 1'b1);
        @(negedge clk);
        chk("abort_ready", cpu_ready, 1);
        chk("abort_active", dma_active, 0);
        chk("abort_done", dma_done, 0);
        chk("abort_pass", bus_addr, CORE);
        chk("abort_rw", bus_rw, 1);
        repeat (20) @(negedge clk);
        chk("abort_q_empty", q.size(), 0);
        xfer(8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter DMA_REG, default 16'h4014, CPU-visible trigger address; a CPU write of page number P starts a transfer.
REQ-002 Parameter DEST_REG, default 16'h2004, fixed write-target address for every transferred byte.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cpu_addr  in  16  core address bus; the core's synchronous-memory timing applies.
REQ-006 cpu_data_o  in  8  core write data.
REQ-007 cpu_rw  in  1  core read/write, 1=read.
REQ-008 cpu_ready  out  1  to core ready input; 0 stalls core read cycles.
REQ-009 mem_data_i  in  8  memory read data, valid the cycle after its address.
REQ-010 bus_addr  out  16  muxed address to memory.
REQ-011 bus_data_o  out  8  muxed write data to memory.
REQ-012 bus_rw  out  1  muxed read/write to memory, 1=read.
REQ-013 dma_active  out  1  high in every state except IDLE.
REQ-014 dma_done  out  1  one-cycle pulse on return to IDLE after a transfer.

Function
REQ-015 States: IDLE, HALT, ALIGN, READ, WRITE, RESUME; state, page, index and parity are registers; all outputs derive combinationally from these registers plus the pass-through inputs.
REQ-016 Parity bit par: 0 after reset, toggles every clk unconditionally.
REQ-017 IDLE: cpu_rw=0 and cpu_addr=DMA_REG -> latch page<=cpu_data_o, index<=0, go HALT next cycle; the trigger write also passes through to memory.
REQ-018 cpu_ready = 1 only in IDLE; 0 in all other states.
REQ-019 IDLE, HALT, ALIGN, RESUME: bus pass-through (bus_addr=cpu_addr, bus_data_o=cpu_data_o, bus_rw=cpu_rw).
REQ-020 HALT: while cpu_rw=0, remain in HALT (core ignores ready on writes; writes complete normally); writes to DMA_REG here are ignored.
REQ-021 HALT with cpu_rw=1 is the stolen halt cycle; next state READ if the next cycle's par is 0, else ALIGN.
REQ-022 ALIGN: exactly one cycle, then READ; READ always occurs with par=0.
REQ-023 READ: bus_addr={page,index}, bus_rw=1, bus_data_o=0; next WRITE.
REQ-024 WRITE: bus_addr=DEST_REG, bus_rw=0, bus_data_o=mem_data_i (data for previous READ address); index increments mod 256.
REQ-025 After WRITE: index was 8'hFF before increment -> RESUME; else READ.
REQ-026 RESUME: one cycle re-presents core's stalled read address so its data is valid when ready rises; next IDLE with dma_done=1 for that IDLE cycle.
REQ-027 cpu_ready low duration: 514 cycles (no ALIGN) or 515 (ALIGN), counted from first HALT cycle with cpu_rw=1 through RESUME.
REQ-028 Exactly 256 reads and 256 writes per transfer, in ascending order {page,00}..{page,FF}; no other DMA-originated bus cycles.
REQ-029 Page FF: addresses FF00..FFFF, no wrap into page 00; index wrap ends transfer only.
REQ-030 Triggers in any state other than IDLE are ignored; no queuing.
REQ-031 Trigger and dma_done coinciding in IDLE: trigger accepted, HALT next cycle.

Reset
REQ-032 rst (any state, including mid-transfer) -> next cycle: state IDLE, page 0, index 0, par 0, cpu_ready=1, dma_active=0, dma_done=0, bus in pass-through.
REQ-033 Transfer aborted by reset is not resumed; no further DMA bus cycles issued.

Verification
REQ-034 Write 8'h02 to 16'h4014, core reads thereafter, halt cycle with next par=0 -> reads 0200..02FF paired with 256 writes to 2004 carrying mem contents; cpu_ready low 514 cycles; one dma_done.
REQ-035 Same but halt cycle lands so next par=1 -> single ALIGN cycle, cpu_ready low 515 cycles, first READ at par=0.
REQ-036 Trigger followed by 2 core write cycles (push pair) -> both writes reach memory unaltered during HALT; halt begins on first core read.
REQ-037 Page 8'hFF -> last read address FFFF, then RESUME; no access to 0000.
REQ-038 rst asserted after 100 WRITEs -> next cycle cpu_ready=1, pass-through, no further 2004 writes; new trigger then performs full 256-byte transfer.
REQ-039 Write to 4014 during transfer (forced via bench) -> ignored; page unchanged, byte count stays 256.
